// File: rtl/seg6_pkg.sv
// Shared constants and types for the six-digit seven-segment scan driver.
// Segment values here are active-high (bit0 = a ... bit6 = g).
package seg6_pkg;

  localparam int NDIG      = 6;
  localparam int NIB_W     = 4;
  localparam int SEG_W     = 7;
  localparam int DIG_IDX_W = 3;
  localparam int BRIGHT_W  = 4;

  typedef logic [NIB_W-1:0]     nibble_t;
  typedef logic [SEG_W-1:0]     seg_t;
  typedef logic [DIG_IDX_W-1:0] dig_idx_t;

  localparam seg_t SEG_OFF = 7'h00;
  localparam seg_t SEG_ALL = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module seg7_hex_decode
  import seg6_pkg::*;
(
  input  nibble_t nib_i,
  output seg_t    seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg6_scan_driver.sv
// Six-digit multiplexed seven-segment scanner: frame-synchronous shadow,
// per-slot dead time, 16-step PWM brightness and leading-zero blanking.
module seg6_scan_driver
  import seg6_pkg::*;
#(
  parameter int SCAN_DIV       = 8192,
  parameter int BLANK_CYCLES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NDIG*NIB_W-1:0]   seg6_export,
  input  logic [NDIG-1:0]         dp_in,
  input  logic                    lz_blank_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NDIG-1:0]         dig_out,
  output logic                    frame_tick
);

  localparam int                  SCAN_W     = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0]   SLOT_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]   SLOT_BLANK = SCAN_W'(BLANK_CYCLES);
  localparam dig_idx_t            DIG_LAST   = DIG_IDX_W'(NDIG - 1);
  localparam seg_t                SEG_IDLE   = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NDIG-1:0]     DIG_IDLE   = {NDIG{DIG_ACTIVE_LOW}};
  localparam logic [NDIG-1:0]     DIG_ONE    = {{(NDIG-1){1'b0}}, 1'b1};

  logic [SCAN_W-1:0]       slot_cnt_q, slot_cnt_d;
  dig_idx_t                digit_idx_q, digit_idx_d;
  logic [NDIG*NIB_W-1:0]   sh_val_q;
  logic [NDIG-1:0]         sh_dp_q;
  logic                    sh_lz_q;
  logic [BRIGHT_W-1:0]     sh_bright_q;
  logic                    frame_tick_q;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NDIG-1:0]         dig_q, dig_d;

  logic                    load;
  logic                    in_window;
  logic [BRIGHT_W-1:0]     phase;
  nibble_t                 nib [NDIG];
  nibble_t                 cur_nib;
  seg_t                    dec_seg;
  logic [NDIG-1:0]         lz_off;
  logic                    higher_zero;

  assign load = (slot_cnt_q == '0) && (digit_idx_q == '0);

  always_comb begin
    slot_cnt_d  = slot_cnt_q + SCAN_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == DIG_LAST) ? '0 : digit_idx_q + DIG_IDX_W'(1);
    end
  end

  always_comb begin
    for (int n = 0; n < NDIG; n++) begin
      nib[n] = sh_val_q[n*NIB_W +: NIB_W];
    end
  end

  // A digit is blanked when it and every more-significant nibble are zero;
  // digit 0 is exempt so a zero value still shows a single "0".
  always_comb begin
    lz_off      = '0;
    higher_zero = 1'b1;
    for (int n = NDIG - 1; n >= 1; n--) begin
      higher_zero = higher_zero & (nib[n] == '0);
      lz_off[n]   = sh_lz_q & higher_zero;
    end
  end

  assign cur_nib   = nib[digit_idx_q];
  assign phase     = slot_cnt_q[SCAN_W-1 -: BRIGHT_W];
  assign in_window = (slot_cnt_q >= SLOT_BLANK) && (phase <= sh_bright_q);

  seg7_hex_decode u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    dig_d = DIG_IDLE;
    seg_d = SEG_IDLE;
    dp_d  = SEG_ACTIVE_LOW;
    if (in_window) begin
      dig_d = (DIG_ONE << digit_idx_q) ^ DIG_IDLE;
      seg_d = (lz_off[digit_idx_q] ? SEG_OFF : dec_seg) ^ SEG_IDLE;
      dp_d  = sh_dp_q[digit_idx_q] ^ SEG_ACTIVE_LOW;
    end
  end

  // Outputs are computed from pre-load shadow on the load edge; slot 0 is
  // always in dead time, so the new frame never shows a mixed value.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= '0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_lz_q      <= 1'b0;
      sh_bright_q  <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_IDLE;
      dp_q         <= SEG_ACTIVE_LOW;
      dig_q        <= DIG_IDLE;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      frame_tick_q <= load;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      if (load) begin
        sh_val_q    <= seg6_export;
        sh_dp_q     <= dp_in;
        sh_lz_q     <= lz_blank_en;
        sh_bright_q <= brightness;
      end
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_out    = dig_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg6_scan_driver.sv
// Directed bench for seg6_scan_driver with a cycle model feeding a scoreboard.
module tb_seg6_scan_driver;

  localparam int SD = 64;
  localparam int BL = 4;
  localparam int BUDGET = 12 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] val;
  logic [5:0]  dp;
  logic        lz;
  logic [3:0]  br;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, ft_a, ft_b;
  logic [5:0]  dig_a, dig_b;

  always #5 clk = ~clk;

  seg6_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .seg6_export(val), .dp_in(dp), .lz_blank_en(lz),
    .brightness(br), .seg_out(seg_a), .dp_out(dp_a), .dig_out(dig_a), .frame_tick(ft_a));

  seg6_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .seg6_export(val), .dp_in(dp), .lz_blank_en(lz),
    .brightness(br), .seg_out(seg_b), .dp_out(dp_b), .dig_out(dig_b), .frame_tick(ft_b));

  typedef struct packed {
    logic       ft;
    logic [5:0] dig;
    logic [6:0] seg;
    logic       dp;
  } pins_t;

  pins_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_slot, m_dig, last_slot, last_dig;
  logic [23:0] s_val;
  logic [5:0]  s_dp;
  logic        s_lz;
  logic [3:0]  s_br;
  logic [6:0]  hex_tbl [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (digit %0d slot %0d)", tag, got, expv, last_dig, last_slot);
    end
  endtask

  function automatic pins_t model_pins();
    pins_t      p;
    logic       act;
    logic       lzoff;
    logic [3:0] nib;
    p.ft  = (m_slot == 0) && (m_dig == 0);
    act   = (m_slot >= BL) && ((m_slot / 4) <= int'(s_br));
    nib   = s_val[4*m_dig +: 4];
    lzoff = s_lz && (m_dig > 0) && ((s_val >> (4*m_dig)) == 24'h0);
    p.dig = act ? ~(6'b000001 << m_dig) : 6'h3F;
    p.seg = (act && !lzoff) ? ~hex_tbl[nib] : 7'h7F;
    p.dp  = act ? ~s_dp[m_dig] : 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_slot = 0; m_dig = 0;
    s_val = '0; s_dp = '0; s_lz = 1'b0; s_br = '0;
    exp_q.delete();
  endtask

  task automatic tick();
    pins_t e;
    @(posedge clk);
    exp_q.push_back(model_pins());
    last_slot = m_slot;
    last_dig  = m_dig;
    if (m_slot == 0 && m_dig == 0) begin
      s_val = val; s_dp = dp; s_lz = lz; s_br = br;
    end
    if (m_slot == SD - 1) begin
      m_slot = 0;
      m_dig  = (m_dig == 5) ? 0 : m_dig + 1;
    end else begin
      m_slot++;
    end
    #1;
    e = exp_q.pop_front();
    check("pins", 32'({ft_a, dig_a, seg_a, dp_a}), 32'(e));
  endtask

  task automatic run_to(input int d, input int s);
    int  n = 0;
    bit  found = 0;
    while (!found && n < BUDGET) begin
      tick();
      n++;
      found = (last_dig == d) && (last_slot == s);
    end
    check("run_to_reached", 32'(found), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a"}, 32'({ft_a, dig_a, seg_a, dp_a}), 32'({1'b0, 6'h3F, 7'h7F, 1'b1}));
    check({tag, "_b"}, 32'({ft_b, dig_b, seg_b, dp_b}), 32'({1'b0, 6'h3F, 7'h7F, 1'b1}));
  endtask

  initial begin
    int n, cnt_a, cnt_b;
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    val = 24'h012345; dp = 6'h00; lz = 1'b0; br = 4'd15;
    last_slot = 0; last_dig = 0;
    model_reset();

    // reset held
    #12;
    check_idle("reset_held");
    @(posedge clk); #1;
    check_idle("reset_held2");
    rst_n = 1'b1;

    tick();
    check("ft_first", 32'(ft_a), 32'd1);
    n = 0;
    do begin tick(); n++; end while (!ft_a && n < 500);
    check("ft_period", 32'(n), 32'd384);

    // 012345, full brightness
    run_to(0, 2);
    check("d0_dead", 32'(dig_a), 32'h3F);
    run_to(0, 4);
    check("d0_on_dig", 32'(dig_a), 32'h3E);
    check("d0_on_seg", 32'(seg_a), 32'h12);
    run_to(0, 63);
    check("d0_last", 32'(dig_a), 32'h3E);
    run_to(1, 10);
    check("d1_seg", 32'(seg_a), 32'h19);
    run_to(5, 30);
    check("d5_dig", 32'(dig_a), 32'h1F);
    check("d5_seg", 32'(seg_a), 32'h40);

    // leading-zero blanking
    val = 24'h000A00; lz = 1'b1;
    run_to(0, 0);
    run_to(1, 10);
    check("lz_d1", 32'(seg_a), 32'h40);
    run_to(2, 10);
    check("lz_d2", 32'(seg_a), 32'h08);
    run_to(3, 10);
    check("lz_d3_dig", 32'(dig_a), 32'h37);
    check("lz_d3_seg", 32'(seg_a), 32'h7F);
    run_to(5, 10);
    check("lz_d5_seg", 32'(seg_a), 32'h7F);
    val = 24'h000000; dp = 6'b000001;
    run_to(0, 0);
    run_to(0, 10);
    check("zero_d0_seg", 32'(seg_a), 32'h40);
    check("zero_d0_dp", 32'(dp_a), 32'd0);
    run_to(1, 10);
    check("zero_d1_seg", 32'(seg_a), 32'h7F);
    check("zero_d1_dp", 32'(dp_a), 32'd1);

    // shadow holds inputs until the next frame
    lz = 1'b0; dp = 6'h00; val = 24'h111111;
    run_to(0, 0);
    run_to(2, 10);
    val = 24'h222222;
    run_to(3, 10);
    check("shadow_d3_old", 32'(seg_a), 32'h79);
    run_to(5, 10);
    check("shadow_d5_old", 32'(seg_a), 32'h79);
    run_to(0, 0);
    check("shadow_ft", 32'(ft_a), 32'd1);
    run_to(3, 10);
    check("shadow_d3_new", 32'(seg_a), 32'h24);

    // brightness
    br = 4'd3;
    run_to(0, 0);
    run_to(1, 15);
    check("br3_on15", 32'(dig_a), 32'h3D);
    run_to(1, 16);
    check("br3_off16", 32'(dig_a), 32'h3F);
    run_to(1, 63);
    cnt_a = 0;
    for (int i = 0; i < SD; i++) begin
      tick();
      if (dig_a != 6'h3F) cnt_a++;
    end
    check("br3_slot_cycles", 32'(cnt_a), 32'd12);
    br = 4'd0;
    run_to(0, 0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6 * SD; i++) begin
      tick();
      if (dig_a != 6'h3F) cnt_a++;
      if (dig_b != 6'h3F) cnt_b++;
    end
    check("br0_blank4", 32'(cnt_a), 32'd0);
    check("br0_blank2", 32'(cnt_b), 32'd12);

    // async reset mid-frame
    br = 4'd15; val = 24'h012345;
    run_to(0, 0);
    run_to(3, 19);
    check("pre_reset_dig", 32'(dig_a), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    model_reset();
    val = 24'h00000F;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("reset_hold");
    end
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (dig_a == 6'h3F && n < 50);
    check("restart_latency", 32'(n), 32'(BL + 1));
    check("restart_dig", 32'(dig_a), 32'h3E);
    check("restart_seg", 32'(seg_a), 32'h0E);
    for (int i = 0; i < 2 * SD; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg6_scan_driver.md
Name: seg6_scan_driver

Overview:
Far-end consumer of the SoC's 24-bit seg6 export. It drives a 6-digit multiplexed common-anode seven-segment display. The 24-bit value holds six hex nibbles (digit 0 = bits [3:0], rightmost). Each nibble is decoded to segments, and the digits are scanned one at a time with inter-digit dead time, PWM brightness, leading-zero blanking and frame-synchronous update.

Parameters:
SCAN_DIV, 8192, clock cycles per digit slot; power of two, >= 32
BLANK_CYCLES, 64, dead-time cycles at start of each slot (all digits off); 1 <= BLANK_CYCLES < SCAN_DIV/2
SEG_ACTIVE_LOW, 1, 1 = seg_out/dp_out active-low
DIG_ACTIVE_LOW, 1, 1 = dig_out active-low

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  asynchronous active-low reset
seg6_export  input  24  six hex nibbles from SoC PIO
dp_in  input  6  decimal point per digit
lz_blank_en  input  1  enable leading-zero blanking
brightness  input  4  0 = 1/16 duty, 15 = full
seg_out  output  7  segments, bit0 = a … bit6 = g
dp_out  output  1  decimal point segment
dig_out  output  6  digit enables, bit n = digit n
frame_tick  output  1  one-cycle pulse at shadow load

Behaviour:
- Reset (async assert, sync release): slot_cnt=0, digit_idx=0, shadow regs=0. All outputs inactive: seg_out=7'h7F/dp_out=1 if SEG_ACTIVE_LOW, else 0. dig_out=6'h3F if DIG_ACTIVE_LOW, else 0. frame_tick=0.
- Counters: slot_cnt runs 0..SCAN_DIV-1. On wrap, digit_idx increments 0..5, then wraps 5->0. Frame = 6*SCAN_DIV cycles.
- Shadow load: when slot_cnt==0 && digit_idx==0, seg6_export, dp_in, lz_blank_en and brightness are registered into the shadow. This includes the first cycle after reset release. Inputs changing at any other time have no effect until the next load.
- frame_tick: registered; high for exactly the one cycle following each shadow-load edge.
- Active window: digit is on iff slot_cnt >= BLANK_CYCLES && phase <= shadow_brightness, where phase = slot_cnt top 4 bits.
- Outputs outside the active window: dig_out all inactive, seg_out/dp_out inactive.
- Outputs inside the active window: only dig_out[digit_idx] active. seg_out = decode(shadow nibble[digit_idx]); dp_out = shadow_dp[digit_idx].
- All outputs registered. Latency is 1 cycle from counter state to pins, uniform for dig/seg/dp, so there is no skew between them. BLANK_CYCLES >= 1 guarantees the shadow update is never visible mid-slot.
- Hex decode (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Polarity inversion is applied after decode.
- Leading-zero blanking (shadow lz_blank_en=1): digit n (n=5..1) has its segments off if its nibble and all higher nibbles are 0. The digit enable still follows the window. dp is unaffected. Digit 0 is never blanked, so 0 displays as a single "0".
- Reset asserted mid-frame: outputs go inactive immediately. After release, scanning restarts at digit 0 with a fresh shadow load.

Decomposition:
- Package seg6_pkg: NDIG=6, nibble width 4, the hex-to-segment constant table (16x7), and active-high segment constants.
- One sub-module, seg7_hex_decode: combinational 4-bit -> 7-bit lookup from the package table. It is instantiated once on the muxed nibble.
- Counters, shadow, blanking mask, PWM compare and output registers live in seg6_scan_driver.

Test Plan:
- Reset held -> seg_out=7F, dp_out=1, dig_out=3F, frame_tick=0. Release -> frame_tick pulses once 1 cycle after release, then every 384 cycles (SCAN_DIV=64).
- SCAN_DIV=64, BLANK=4, brightness=15, seg6_export=24'h012345 -> digit0: dig_out=6'b111110 for slot cycles 4..63 (pin time +1) with seg_out=~6D. Digit5 shows seg_out=~3F. Cycles 0..3 of each slot all off.
- lz_blank_en=1, seg6_export=24'h000A00 -> digits 5,4,3 seg_out=7F while enabled. Digit2 seg_out=~77. Digits 1,0 seg_out=~3F. With export=0 only digit0 lit with ~3F.
- Change seg6_export from 24'h111111 to 24'h222222 during digit 2 -> digits 3..5 still show "1" this frame; "2" appears from the next frame_tick.
- brightness=3, SCAN_DIV=64, BLANK=4 -> digit on for slot_cnt 4..15 only (12 cycles/slot). brightness=0 -> slot_cnt 4..3 is empty, so the digit is never on. Check the 1/16 boundary: with BLANK=2, on for cycles 2..3.
- Assert reset during digit 3, slot_cnt=20 -> outputs inactive same cycle (async). After release, dig_out first activates digit0 at slot_cnt=BLANK(+1), with shadow reloaded.
